// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button sequencing, tick prescaler and digit carry chain for the stopwatch.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module stopwatch_ctrl #(
   parameter int CLK_DIV = 100,
   parameter int NDIG    = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              btn_start_i,
   input  logic              btn_clear_i,
   input  logic              btn_set_i,
   input  logic              dir_in_i,
   input  logic [4*NDIG-1:0] digits_i,
   output logic [NDIG-1:0]   inc_o,
   output logic              dir_o,
   output logic              load_o,
   output logic              clr_o,
   output logic              running_o,
   output logic              done_o
);

   localparam int            PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_SET   = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic            start_q, clear_q, set_q;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic            tick_q, tick_d;
   logic            dir_q, dir_d;
   logic            clr_q;

   logic            start_edge, clear_edge, set_edge;
   logic [NDIG-1:0] term;
   logic            full_scale;

   assign start_edge = btn_start_i & ~start_q;
   assign clear_edge = btn_clear_i & ~clear_q;
   assign set_edge   = btn_set_i & ~set_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         clear_q <= 1'b0;
         set_q   <= 1'b0;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         dir_q   <= 1'b1;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= btn_start_i;
         clear_q <= btn_clear_i;
         set_q   <= btn_set_i;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         dir_q   <= dir_d;
         clr_q   <= clear_edge;
      end
   end

   // Odd digits are tens-of-seconds/minutes and stop at 5.
   always_comb begin
      term = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (dir_q) begin
            term[i] = (digits_i[4*i +: 4] == ((i % 2 == 0) ? 4'd9 : 4'd5));
         end else begin
            term[i] = (digits_i[4*i +: 4] == 4'd0);
         end
      end
   end

   assign full_scale = tick_q & (&term);

   always_comb begin
      logic carry;
      inc_o = '0;
      carry = (state_q == S_RUN) && tick_q && !full_scale;
      for (int i = 0; i < NDIG; i++) begin
         inc_o[i] = carry;
         carry    = carry & term[i];
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;

      if (state_q == S_RUN) begin
         tick_d = (cnt_q == PMAX);
         cnt_d  = (cnt_q == PMAX) ? '0 : cnt_q + PW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (clear_edge) begin
               state_d = S_IDLE;
            end else if (set_edge) begin
               state_d = S_SET;
            end else if (start_edge) begin
               dir_d   = dir_in_i;
               cnt_d   = '0;
               state_d = (!dir_in_i && (digits_i == '0)) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // A full-scale tick wins over a pause request in the same cycle.
            if (clear_edge) begin
               state_d = S_IDLE;
            end else if (full_scale) begin
               state_d = S_DONE;
            end else if (start_edge) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (clear_edge) begin
               state_d = S_IDLE;
            end else if (start_edge) begin
               state_d = S_RUN;
            end
         end
         S_SET: begin
            if (clear_edge || set_edge) begin
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            if (clear_edge) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dir_o     = dir_q;
   assign load_o    = (state_q == S_SET);
   assign clr_o     = clr_q;
   assign running_o = (state_q == S_RUN);
   assign done_o    = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed vector table, corner sequences and random stimulus for stopwatch_ctrl.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

   localparam int CLK_DIV = 4;
   localparam int NDIG    = 4;
   localparam int TMAX    = 3599;

   logic        clk, rst_n;
   logic        btn_start, btn_clear, btn_set, dir_in;
   logic [15:0] digits;
   logic [3:0]  inc_o;
   logic        dir_o, load_o, clr_o, running_o, done_o;
   logic [15:0] sv;

   int errors = 0;
   int checks = 0;

   stopwatch_ctrl #(.CLK_DIV(CLK_DIV), .NDIG(NDIG)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .btn_start_i(btn_start), .btn_clear_i(btn_clear), .btn_set_i(btn_set),
      .dir_in_i(dir_in), .digits_i(digits),
      .inc_o(inc_o), .dir_o(dir_o), .load_o(load_o), .clr_o(clr_o),
      .running_o(running_o), .done_o(done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digit chain the controller drives: clear > load > advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits <= '0;
      end else if (clr_o) begin
         digits <= '0;
      end else if (load_o) begin
         digits <= sv;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (inc_o[i]) begin
               if (dir_o) digits[4*i +: 4] <= (digits[4*i +: 4] == ((i % 2 == 0) ? 4'd9 : 4'd5)) ? 4'd0 : digits[4*i +: 4] + 4'd1;
               else       digits[4*i +: 4] <= (digits[4*i +: 4] == 4'd0) ? ((i % 2 == 0) ? 4'd9 : 4'd5) : digits[4*i +: 4] - 4'd1;
            end
         end
      end
   end

   // Reference model: time held as total seconds, carries derived from which digits change.
   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_SET, M_DONE} mstate_t;
   mstate_t m_st;
   bit      m_pst, m_pcl, m_pse, m_tick, m_dir, m_clr;
   int      m_cnt, m_t;

   function automatic int dig_of(int t, int i);
      case (i)
         0:       return t % 10;
         1:       return (t / 10) % 6;
         2:       return (t / 60) % 10;
         default: return t / 600;
      endcase
   endfunction

   function automatic logic [15:0] t2bcd(int t);
      logic [15:0] b;
      for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'(dig_of(t, i));
      return b;
   endfunction

   function automatic int bcd2t(logic [15:0] b);
      return int'(b[15:12]) * 600 + int'(b[11:8]) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit at_limit(int t, bit up);
      return up ? (t == TMAX) : (t == 0);
   endfunction

   function automatic logic [3:0] exp_inc();
      logic [3:0] m;
      int nt;
      m = '0;
      if (m_st == M_RUN && m_tick && !at_limit(m_t, m_dir)) begin
         nt = m_dir ? m_t + 1 : m_t - 1;
         for (int i = 0; i < 4; i++) m[i] = (dig_of(m_t, i) != dig_of(nt, i));
      end
      return m;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit es, ec, ese, fs, ntick, ndir;
      mstate_t ns;
      int nt, ncnt;
      if (!rst_n) begin
         m_st <= M_IDLE; m_pst <= 0; m_pcl <= 0; m_pse <= 0;
         m_cnt <= 0; m_tick <= 0; m_dir <= 1; m_clr <= 0; m_t <= 0;
      end else begin
         es = btn_start & !m_pst;
         ec = btn_clear & !m_pcl;
         ese = btn_set & !m_pse;
         fs = (m_st == M_RUN) && m_tick && at_limit(m_t, m_dir);
         ns = m_st; nt = m_t; ncnt = m_cnt; ntick = 0; ndir = m_dir;
         if (m_clr) nt = 0;
         else if (m_st == M_SET) nt = bcd2t(sv);
         else if (exp_inc() != 0) nt = m_dir ? m_t + 1 : m_t - 1;
         if (m_st == M_RUN) begin
            ncnt  = (m_cnt + 1) % CLK_DIV;
            ntick = (ncnt == 0);
         end
         if (ec) ns = M_IDLE;
         else begin
            case (m_st)
               M_IDLE:  if (ese) ns = M_SET;
                        else if (es) begin
                           ndir = dir_in; ncnt = 0;
                           ns = (!dir_in && m_t == 0) ? M_DONE : M_RUN;
                        end
               M_RUN:   if (fs) ns = M_DONE; else if (es) ns = M_PAUSE;
               M_PAUSE: if (es) ns = M_RUN;
               M_SET:   if (ese) ns = M_IDLE;
               default: ns = m_st;
            endcase
         end
         m_st <= ns; m_t <= nt; m_cnt <= ncnt; m_tick <= ntick; m_dir <= ndir;
         m_clr <= ec; m_pst <= btn_start; m_pcl <= btn_clear; m_pse <= btn_set;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("model_running", 32'(running_o), 32'(m_st == M_RUN));
      chk("model_done",    32'(done_o),    32'(m_st == M_DONE));
      chk("model_load",    32'(load_o),    32'(m_st == M_SET));
      chk("model_clr",     32'(clr_o),     32'(m_clr));
      chk("model_dir",     32'(dir_o),     32'(m_dir));
      chk("model_inc",     32'(inc_o),     32'(exp_inc()));
      chk("model_digits",  32'(digits),    32'(t2bcd(m_t)));
   endtask

   task automatic step(input bit st, input bit cl, input bit se, input bit di);
      btn_start = st; btn_clear = cl; btn_set = se; dir_in = di;
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_inc"},     32'(inc_o),     32'h0);
      chk({tag, "_dir"},     32'(dir_o),     32'h1);
      chk({tag, "_load"},    32'(load_o),    32'h0);
      chk({tag, "_clr"},     32'(clr_o),     32'h0);
      chk({tag, "_running"}, 32'(running_o), 32'h0);
      chk({tag, "_done"},    32'(done_o),    32'h0);
   endtask

   typedef struct {
      bit st, cl, se, di;
      logic [15:0] sv;
      int reps;
      bit run, done, load, clr;
      logic [3:0]  inc;
      logic [15:0] dig;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit st, bit cl, bit se, bit di, logic [15:0] s, int reps,
                               bit run, bit done, bit load, bit clr, logic [3:0] inc, logic [15:0] dig);
      vec_t v;
      v.st = st; v.cl = cl; v.se = se; v.di = di; v.sv = s; v.reps = reps;
      v.run = run; v.done = done; v.load = load; v.clr = clr; v.inc = inc; v.dig = dig;
      return v;
   endfunction

   initial begin
      bit b_st, b_cl, b_se;
      int n, t;

      rst_n = 1'b0; btn_start = 0; btn_clear = 0; btn_set = 0; dir_in = 1; sv = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_reset_values("reset");

      //            st cl se di sv        reps run dn ld cl inc    dig
      tbl.push_back(mk(0, 0, 1, 1, 16'h0009, 1,  0, 0, 1, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(0, 0, 1, 1, 16'h0009, 1,  0, 0, 1, 0, 4'h0, 16'h0009));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 1,  0, 0, 1, 0, 4'h0, 16'h0009));
      tbl.push_back(mk(0, 0, 1, 1, 16'h0009, 1,  0, 0, 0, 0, 4'h0, 16'h0009));
      tbl.push_back(mk(1, 0, 0, 1, 16'h0009, 1,  1, 0, 0, 0, 4'h0, 16'h0009));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 3,  1, 0, 0, 0, 4'h0, 16'h0009));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 1,  1, 0, 0, 0, 4'h3, 16'h0009));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 1,  1, 0, 0, 0, 4'h0, 16'h0010));
      tbl.push_back(mk(1, 0, 0, 1, 16'h0009, 1,  0, 0, 0, 0, 4'h0, 16'h0010));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 10, 0, 0, 0, 0, 4'h0, 16'h0010));
      tbl.push_back(mk(1, 0, 0, 1, 16'h0009, 1,  1, 0, 0, 0, 4'h0, 16'h0010));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 1,  1, 0, 0, 0, 4'h0, 16'h0010));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 1,  1, 0, 0, 0, 4'h1, 16'h0010));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 1,  1, 0, 0, 0, 4'h0, 16'h0011));
      tbl.push_back(mk(1, 1, 1, 1, 16'h0009, 1,  0, 0, 0, 1, 4'h0, 16'h0011));
      tbl.push_back(mk(0, 0, 0, 1, 16'h0009, 1,  0, 0, 0, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(1, 0, 0, 0, 16'h0009, 1,  0, 1, 0, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(0, 0, 0, 0, 16'h0009, 6,  0, 1, 0, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(1, 0, 0, 0, 16'h0009, 1,  0, 1, 0, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(0, 0, 0, 0, 16'h0009, 1,  0, 1, 0, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(0, 1, 0, 0, 16'h0009, 1,  0, 0, 0, 1, 4'h0, 16'h0000));
      tbl.push_back(mk(0, 0, 0, 0, 16'h0009, 1,  0, 0, 0, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(0, 0, 1, 1, 16'h5959, 1,  0, 0, 1, 0, 4'h0, 16'h0000));
      tbl.push_back(mk(0, 0, 0, 1, 16'h5959, 1,  0, 0, 1, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(0, 0, 1, 1, 16'h5959, 1,  0, 0, 0, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(1, 0, 0, 1, 16'h5959, 1,  1, 0, 0, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(0, 0, 0, 1, 16'h5959, 3,  1, 0, 0, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(0, 0, 0, 1, 16'h5959, 1,  1, 0, 0, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(0, 0, 0, 1, 16'h5959, 1,  0, 1, 0, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(1, 0, 0, 1, 16'h5959, 1,  0, 1, 0, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(0, 0, 0, 1, 16'h5959, 1,  0, 1, 0, 0, 4'h0, 16'h5959));
      tbl.push_back(mk(0, 1, 0, 1, 16'h5959, 1,  0, 0, 0, 1, 4'h0, 16'h5959));
      tbl.push_back(mk(0, 0, 0, 1, 16'h5959, 1,  0, 0, 0, 0, 4'h0, 16'h0000));

      for (int r = 0; r < tbl.size(); r++) begin
         for (int k = 0; k < tbl[r].reps; k++) begin
            sv = tbl[r].sv;
            step(tbl[r].st, tbl[r].cl, tbl[r].se, tbl[r].di);
            chk($sformatf("vec%0d_rep%0d", r, k),
                {8'h0, running_o, done_o, load_o, clr_o, inc_o, digits},
                {8'h0, tbl[r].run, tbl[r].done, tbl[r].load, tbl[r].clr, tbl[r].inc, tbl[r].dig});
         end
      end

      // Full scale from 59:58: one real tick, then the terminal tick, then DONE.
      sv = t2bcd(TMAX - 1);
      step(0, 0, 1, 1); step(0, 0, 0, 1); step(0, 0, 1, 1); step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      n = 0;
      while (!done_o && n < 20) begin
         step(0, 0, 0, 1);
         n++;
      end
      chk("fullscale_latency", 32'(n), 32'd9);

      // Async reset in the middle of a down count.
      step(0, 1, 0, 0); step(0, 0, 0, 0);
      sv = t2bcd(5);
      step(0, 0, 1, 1); step(0, 0, 0, 1); step(0, 0, 1, 1); step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0);
      chk("down_dir_latched", 32'(dir_o), 32'h0);
      chk("down_running", 32'(running_o), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_values("async_reset");
      #2;
      rst_n = 1'b1;

      b_st = 0; b_cl = 0; b_se = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(5) == 0)  b_st = !b_st;
         if ($urandom_range(24) == 0) b_cl = !b_cl;
         if ($urandom_range(9) == 0)  b_se = !b_se;
         if ($urandom_range(9) == 0) begin
            case ($urandom_range(2))
               0:       t = $urandom_range(TMAX);
               1:       t = TMAX - $urandom_range(3);
               default: t = $urandom_range(3);
            endcase
            sv = t2bcd(t);
         end
         step(b_st, b_cl, b_se, 1'($urandom_range(1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
